// File: rtl/algo_mrpnwp_1r1w_pmem.sv
// algo_mrpnwp_1r1w_pmem: physical-side circular store for the addressless multi-port queue core
// Ports: clk/rst (sync, active-high); ready after reset; pwrite/pdin push words,
// pread pops them; t1_doutB/vread_vld_bus/vread_padr_bus return popped words
// SRAM_DELAY cycles later; count/full/empty occupancy; wr_ovfl/rd_udfl drop pulses.
module algo_mrpnwp_1r1w_pmem #(
    parameter int WIDTH      = 32,
    parameter int NUMRDPT    = 2,
    parameter int NUMWRPT    = 3,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int BITPADR    = 13,
    parameter int SRAM_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUMWRPT-1:0]         pwrite,
    input  logic [NUMWRPT*WIDTH-1:0]   pdin,
    input  logic [NUMRDPT-1:0]         pread,
    output logic [NUMRDPT*WIDTH-1:0]   t1_doutB,
    output logic [NUMRDPT-1:0]         vread_vld_bus,
    output logic [NUMRDPT*BITPADR-1:0] vread_padr_bus,
    output logic [BITADDR:0]           count,
    output logic                       full,
    output logic                       empty,
    output logic                       wr_ovfl,
    output logic                       rd_udfl
);
    localparam logic [BITADDR:0] NA = (BITADDR+1)'(NUMADDR);
    localparam int PI = SRAM_DELAY > 1 ? SRAM_DELAY - 2 : 0;

    logic [WIDTH-1:0]           mem_q [NUMADDR];
    logic                       ready_q, wr_ovfl_q, rd_udfl_q;
    logic [BITADDR:0]           count_q, count_d;
    logic [BITADDR-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NUMWRPT-1:0]         wacc;
    logic [NUMWRPT*BITADDR-1:0] wadr;
    logic [NUMRDPT-1:0]         racc;
    logic [NUMRDPT*BITADDR-1:0] radr;
    logic                       wdrop, rdrop;
    logic [NUMRDPT-1:0]         vld_q [SRAM_DELAY];
    logic [NUMRDPT*BITADDR-1:0] adr_q [SRAM_DELAY];
    logic [NUMRDPT-1:0]         pre_vld;
    logic [NUMRDPT*BITADDR-1:0] pre_adr;
    logic [NUMRDPT*WIDTH-1:0]   dout_q;

    // operands stay below 2*NUMADDR, so one conditional subtract is a full modulo
    function automatic logic [BITADDR-1:0] wrap(input logic [BITADDR:0] a);
        logic [BITADDR:0] s;
        s = a >= NA ? a - NA : a;
        return s[BITADDR-1:0];
    endfunction

    // priority scan from port 0: running rank doubles as the address offset
    always_comb begin
        logic [BITADDR:0] wn, rn;
        wn = '0;
        rn = '0;
        wacc = '0;
        racc = '0;
        wadr = '0;
        radr = '0;
        wdrop = 1'b0;
        rdrop = 1'b0;
        for (int i = 0; i < NUMWRPT; i++) begin
            wacc[i] = ready_q && pwrite[i] && (wn < NA - count_q);
            wadr[i*BITADDR +: BITADDR] = wacc[i] ? wrap({1'b0, wptr_q} + wn) : '0;
            wdrop = wdrop | (ready_q && pwrite[i] && !wacc[i]);
            wn = wn + {{BITADDR{1'b0}}, wacc[i]};
        end
        for (int i = 0; i < NUMRDPT; i++) begin
            racc[i] = ready_q && pread[i] && (rn < count_q);
            radr[i*BITADDR +: BITADDR] = racc[i] ? wrap({1'b0, rptr_q} + rn) : '0;
            rdrop = rdrop | (ready_q && pread[i] && !racc[i]);
            rn = rn + {{BITADDR{1'b0}}, racc[i]};
        end
        wptr_d = wrap({1'b0, wptr_q} + wn);
        rptr_d = wrap({1'b0, rptr_q} + rn);
        count_d = count_q + wn - rn;
    end

    // stage feeding the data register; with a one-cycle delay that is the request itself
    assign pre_vld = SRAM_DELAY == 1 ? racc : vld_q[PI];
    assign pre_adr = SRAM_DELAY == 1 ? radr : adr_q[PI];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUMWRPT; i++)
            if (wacc[i]) mem_q[wadr[i*BITADDR +: BITADDR]] <= pdin[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q   <= 1'b0;
            wr_ovfl_q <= 1'b0;
            rd_udfl_q <= 1'b0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            dout_q    <= '0;
            for (int j = 0; j < SRAM_DELAY; j++) begin
                vld_q[j] <= '0;
                adr_q[j] <= '0;
            end
        end else begin
            ready_q   <= 1'b1;
            wr_ovfl_q <= wdrop;
            rd_udfl_q <= rdrop;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            vld_q[0]  <= racc;
            adr_q[0]  <= radr;
            for (int j = 1; j < SRAM_DELAY; j++) begin
                vld_q[j] <= vld_q[j-1];
                adr_q[j] <= adr_q[j-1];
            end
            for (int i = 0; i < NUMRDPT; i++)
                dout_q[i*WIDTH +: WIDTH] <= pre_vld[i] ? mem_q[pre_adr[i*BITADDR +: BITADDR]] : '0;
        end
    end

    // invalid lanes carry a zero address through the pipe, so zero-extension is all that is left
    always_comb begin
        vread_padr_bus = '0;
        for (int i = 0; i < NUMRDPT; i++)
            vread_padr_bus[i*BITPADR +: BITADDR] = adr_q[SRAM_DELAY-1][i*BITADDR +: BITADDR];
    end

    assign ready         = ready_q;
    assign count         = count_q;
    assign full          = count_q == NA;
    assign empty         = count_q == '0;
    assign wr_ovfl       = wr_ovfl_q;
    assign rd_udfl       = rd_udfl_q;
    assign t1_doutB      = dout_q;
    assign vread_vld_bus = vld_q[SRAM_DELAY-1];
endmodule

// File: tb/tb_algo_mrpnwp_1r1w_pmem.sv
// tb_algo_mrpnwp_1r1w_pmem: directed scoreboard bench for the physical-side queue store
module tb_algo_mrpnwp_1r1w_pmem;
    logic        clk = 0, rst = 1, ready, full, empty, wr_ovfl, rd_udfl;
    logic [2:0]  pwrite = '0;
    logic [23:0] pdin = '0;
    logic [1:0]  pread = '0, vld;
    logic [15:0] dout;
    logic [5:0]  padr;
    logic [3:0]  count;
    int total = 0, bad = 0, cyc = 0;
    bit mon = 0;

    typedef struct { int c; logic [7:0] d; logic [2:0] a; } e_t;
    e_t q [2][$];

    algo_mrpnwp_1r1w_pmem #(.WIDTH(8), .NUMRDPT(2), .NUMWRPT(3), .NUMADDR(8),
        .BITADDR(3), .BITPADR(3), .SRAM_DELAY(2)) dut (
        .clk(clk), .rst(rst), .ready(ready), .pwrite(pwrite), .pdin(pdin), .pread(pread),
        .t1_doutB(dout), .vread_vld_bus(vld), .vread_padr_bus(padr), .count(count),
        .full(full), .empty(empty), .wr_ovfl(wr_ovfl), .rd_udfl(rd_udfl));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (mon) for (int p = 0; p < 2; p++) begin
        if (q[p].size() != 0 && q[p][0].c == cyc) begin
            chk($sformatf("vld%0d", p), int'(vld[p]), 1);
            chk($sformatf("dout%0d", p), int'(dout[p*8 +: 8]), int'(q[p][0].d));
            chk($sformatf("padr%0d", p), int'(padr[p*3 +: 3]), int'(q[p][0].a));
            void'(q[p].pop_front());
        end else begin
            chk($sformatf("idle%0d", p), int'({vld[p], dout[p*8 +: 8], padr[p*3 +: 3]}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] pw, input logic [23:0] d, input logic [1:0] pr);
        pwrite = pw;
        pdin = d;
        pread = pr;
        tick();
        pwrite = '0;
        pread = '0;
    endtask

    task automatic ex(input int p, input logic [7:0] d, input logic [2:0] a);
        q[p].push_back('{cyc + 2, d, a});
    endtask

    task automatic st(input string n, input int c, input bit ov, input bit ud);
        chk({n, ".count"}, int'(count), c);
        chk({n, ".full"}, int'(full), int'(c == 8));
        chk({n, ".empty"}, int'(empty), int'(c == 0));
        chk({n, ".wr_ovfl"}, int'(wr_ovfl), int'(ov));
        chk({n, ".rd_udfl"}, int'(rd_udfl), int'(ud));
    endtask

    initial begin
        #1;
        tick();
        mon = 1;
        rst = 0;
        chk("ready_after_rst", int'(ready), 0);
        st("rst", 0, 0, 0);
        step(3'b111, 24'h112233, 2'b11);
        chk("ready_up", int'(ready), 1);
        st("ignored", 0, 0, 0);
        // two pushes then two pops
        step(3'b101, {8'hA2, 8'h00, 8'hA0}, 2'b00);
        st("push2", 2, 0, 0);
        ex(0, 8'hA0, 0); ex(1, 8'hA2, 1);
        step(3'b000, 24'h0, 2'b11);
        st("pop2", 0, 0, 0);
        tick(); tick();
        // fill 2..7,0,1
        step(3'b111, {8'hB2, 8'hB1, 8'hB0}, 2'b00);
        st("fill1", 3, 0, 0);
        step(3'b111, {8'hC2, 8'hC1, 8'hC0}, 2'b00);
        st("fill2", 6, 0, 0);
        step(3'b011, {8'h00, 8'hD1, 8'hD0}, 2'b00);
        st("fill3", 8, 0, 0);
        step(3'b111, {8'hEE, 8'hEE, 8'hEE}, 2'b00);
        st("ovfl", 8, 1, 0);
        // full: a same-cycle write cannot use the slots freed by reads
        ex(0, 8'hB0, 2); ex(1, 8'hB1, 3);
        step(3'b001, 24'h0000FF, 2'b11);
        st("full_rw", 6, 1, 0);
        ex(0, 8'hB2, 4); ex(1, 8'hC0, 5);
        step(3'b000, 24'h0, 2'b11);
        st("rd_b", 4, 0, 0);
        ex(0, 8'hC1, 6); ex(1, 8'hC2, 7);
        step(3'b000, 24'h0, 2'b11);
        st("rd_c", 2, 0, 0);
        ex(0, 8'hD0, 0);
        step(3'b000, 24'h0, 2'b01);
        st("rd_d", 1, 0, 0);
        ex(0, 8'hD1, 1);
        step(3'b000, 24'h0, 2'b11);
        st("udfl", 0, 0, 1);
        step(3'b000, 24'h0, 2'b10);
        st("udfl_empty", 0, 0, 1);
        // move both pointers to 6
        step(3'b111, {8'hE2, 8'hE1, 8'hE0}, 2'b00);
        step(3'b001, {8'h00, 8'h00, 8'hE3}, 2'b00);
        st("adv_w", 4, 0, 0);
        ex(0, 8'hE0, 2); ex(1, 8'hE1, 3);
        step(3'b000, 24'h0, 2'b11);
        ex(0, 8'hE2, 4); ex(1, 8'hE3, 5);
        step(3'b000, 24'h0, 2'b11);
        st("adv_r", 0, 0, 0);
        // wrap: 6,7,0
        step(3'b111, {8'hF2, 8'hF1, 8'hF0}, 2'b00);
        st("wrap_w", 3, 0, 0);
        ex(0, 8'hF0, 6); ex(1, 8'hF1, 7);
        step(3'b000, 24'h0, 2'b11);
        st("wrap_r", 1, 0, 0);
        // same-cycle push is invisible to pops
        ex(0, 8'hF2, 0);
        step(3'b001, {8'h00, 8'h00, 8'h60}, 2'b11);
        st("same_cyc", 1, 0, 1);
        ex(1, 8'h60, 1);
        step(3'b000, 24'h0, 2'b10);
        st("port1_only", 0, 0, 0);
        tick(); tick();
        // reset mid-read: nothing comes back
        step(3'b011, {8'h00, 8'h71, 8'h70}, 2'b00);
        st("pre_rst", 2, 0, 0);
        step(3'b000, 24'h0, 2'b11);
        rst = 1;
        tick();
        rst = 0;
        st("mid_rst", 0, 0, 0);
        chk("mid_rst.ready", int'(ready), 0);
        repeat (4) tick();
        chk("drain", q[0].size() + q[1].size(), 0);
        mon = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
